// File: rtl/video_pkg.sv
// Shared types and constants for the AXI4-Stream video pattern generator:
// FSM state encoding, pattern codes, colour-bar palette and pixel packing.
package video_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StHblank = 2'd2,
        StVblank = 2'd3
    } state_e;

    localparam logic [1:0] PatBars    = 2'd0;
    localparam logic [1:0] PatHramp   = 2'd1;
    localparam logic [1:0] PatVramp   = 2'd2;
    localparam logic [1:0] PatChecker = 2'd3;

    localparam logic [23:0] ColWhite   = 24'hFFFFFF;
    localparam logic [23:0] ColYellow  = 24'hFFFF00;
    localparam logic [23:0] ColCyan    = 24'h00FFFF;
    localparam logic [23:0] ColGreen   = 24'h00FF00;
    localparam logic [23:0] ColMagenta = 24'hFF00FF;
    localparam logic [23:0] ColRed     = 24'hFF0000;
    localparam logic [23:0] ColBlue    = 24'h0000FF;
    localparam logic [23:0] ColBlack   = 24'h000000;

    function automatic logic [23:0] pack_pixel(input logic [7:0] r, input logic [7:0] g,
                                               input logic [7:0] b);
        return {r, g, b};
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] col;
        unique case (idx)
            3'd0:    col = ColWhite;
            3'd1:    col = ColYellow;
            3'd2:    col = ColCyan;
            3'd3:    col = ColGreen;
            3'd4:    col = ColMagenta;
            3'd5:    col = ColRed;
            3'd6:    col = ColBlue;
            default: col = ColBlack;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: maps position, bar index, pattern code and
// frame parity to a packed 24-bit RGB pixel.
module video_pattern_pixel
    import video_pkg::*;
(
    input  logic [7:0]  i_x,
    input  logic [7:0]  i_y,
    input  logic [2:0]  i_bar_idx,
    input  logic [1:0]  i_pat,
    input  logic        i_f0,
    output logic [23:0] o_pixel
);

    always_comb begin
        o_pixel = '0;
        unique case (i_pat)
            PatBars:    o_pixel = bar_colour(i_bar_idx);
            PatHramp:   o_pixel = pack_pixel(i_x, i_x, i_x);
            PatVramp:   o_pixel = pack_pixel(i_y, i_y, i_y);
            PatChecker: o_pixel = (i_x[3] ^ i_y[3] ^ i_f0) ? ColWhite : ColBlack;
            default:    o_pixel = '0;
        endcase
    end

endmodule

// File: rtl/axis_video_pattern_gen.sv
// AXI4-Stream test-frame source: whole frames only, SOF on tuser, EOL on tlast,
// registered outputs that hold steady under tready backpressure.
module axis_video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_BLANK  = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic        m_axis_video_tready,
    output logic [23:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        frame_done,
    output logic [15:0] frame_count
);

    localparam int unsigned XW        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BAR_W     = H_ACTIVE / 8;
    localparam int unsigned BCW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int unsigned BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BLW       = (BLANK_MAX > 1) ? $clog2(BLANK_MAX + 1) : 1;

    localparam logic [XW-1:0]  X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]  Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BCW-1:0] BAR_LAST = BCW'(BAR_W - 1);
    localparam logic [BLW-1:0] HB_LOAD  = (H_BLANK > 0) ? BLW'(H_BLANK - 1) : '0;
    localparam logic [BLW-1:0] VB_LOAD  = (V_BLANK > 0) ? BLW'(V_BLANK - 1) : '0;

    state_e         r_state, w_state_d;
    logic [XW-1:0]  r_x, w_x_d;
    logic [YW-1:0]  r_y, w_y_d;
    logic [BCW-1:0] r_bar_cnt, w_bar_cnt_d;
    logic [2:0]     r_bar_idx, w_bar_idx_d;
    logic [BLW-1:0] r_blank, w_blank_d;
    logic [1:0]     r_pat, w_pat_d;
    logic           r_f0, w_f0_d;
    logic [15:0]    r_frame_count, w_frame_count_d;
    logic           r_frame_done, w_frame_done_d;

    logic [23:0]    r_tdata, w_tdata_d;
    logic           r_tvalid, w_tvalid_d;
    logic           r_tuser, w_tuser_d;
    logic           r_tlast, w_tlast_d;

    logic           w_xfer;
    logic           w_start;
    logic [7:0]     w_x8;
    logic [7:0]     w_y8;
    logic [23:0]    w_pixel;

    assign w_xfer = r_tvalid & m_axis_video_tready;

    always_comb begin
        w_state_d       = r_state;
        w_x_d           = r_x;
        w_y_d           = r_y;
        w_bar_cnt_d     = r_bar_cnt;
        w_bar_idx_d     = r_bar_idx;
        w_blank_d       = r_blank;
        w_pat_d         = r_pat;
        w_f0_d          = r_f0;
        w_frame_count_d = r_frame_count;
        w_frame_done_d  = 1'b0;
        w_start         = 1'b0;

        unique case (r_state)
            StIdle: w_start = enable;
            StActive: begin
                if (w_xfer) begin
                    if (r_x != X_LAST) begin
                        w_x_d = r_x + 1'b1;
                        if (r_bar_cnt == BAR_LAST) begin
                            w_bar_cnt_d = '0;
                            w_bar_idx_d = r_bar_idx + 1'b1;
                        end else begin
                            w_bar_cnt_d = r_bar_cnt + 1'b1;
                        end
                    end else begin
                        w_x_d       = '0;
                        w_bar_cnt_d = '0;
                        w_bar_idx_d = '0;
                        if (r_y != Y_LAST) begin
                            w_y_d = r_y + 1'b1;
                            if (H_BLANK != 0) begin
                                w_state_d = StHblank;
                                w_blank_d = HB_LOAD;
                            end
                        end else begin
                            w_y_d           = '0;
                            w_frame_done_d  = 1'b1;
                            w_frame_count_d = r_frame_count + 16'd1;
                            if (V_BLANK != 0) begin
                                w_state_d = StVblank;
                                w_blank_d = VB_LOAD;
                            end else if (enable) begin
                                w_start = 1'b1;
                            end else begin
                                w_state_d = StIdle;
                            end
                        end
                    end
                end
            end
            StHblank: begin
                if (r_blank == '0) begin
                    w_state_d = StActive;
                end else begin
                    w_blank_d = r_blank - 1'b1;
                end
            end
            StVblank: begin
                if (r_blank == '0) begin
                    if (enable) begin
                        w_start = 1'b1;
                    end else begin
                        w_state_d = StIdle;
                    end
                end else begin
                    w_blank_d = r_blank - 1'b1;
                end
            end
            default: w_state_d = StIdle;
        endcase

        // Frame parity uses the count including a frame that completes this cycle.
        if (w_start) begin
            w_state_d   = StActive;
            w_x_d       = '0;
            w_y_d       = '0;
            w_bar_cnt_d = '0;
            w_bar_idx_d = '0;
            w_pat_d     = pattern_sel;
            w_f0_d      = w_frame_count_d[0];
        end
    end

    assign w_x8 = 8'(w_x_d);
    assign w_y8 = 8'(w_y_d);

    video_pattern_pixel u_pixel (
        .i_x       (w_x8),
        .i_y       (w_y8),
        .i_bar_idx (w_bar_idx_d),
        .i_pat     (w_pat_d),
        .i_f0      (w_f0_d),
        .o_pixel   (w_pixel)
    );

    // Outputs are a pure function of next state, so a stall holds them unchanged.
    always_comb begin
        w_tvalid_d = (w_state_d == StActive);
        w_tdata_d  = w_tvalid_d ? w_pixel : '0;
        w_tuser_d  = w_tvalid_d && (w_x_d == '0) && (w_y_d == '0);
        w_tlast_d  = w_tvalid_d && (w_x_d == X_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= StIdle;
            r_x           <= '0;
            r_y           <= '0;
            r_bar_cnt     <= '0;
            r_bar_idx     <= '0;
            r_blank       <= '0;
            r_pat         <= '0;
            r_f0          <= 1'b0;
            r_frame_count <= '0;
            r_frame_done  <= 1'b0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_tuser       <= 1'b0;
            r_tlast       <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_x           <= w_x_d;
            r_y           <= w_y_d;
            r_bar_cnt     <= w_bar_cnt_d;
            r_bar_idx     <= w_bar_idx_d;
            r_blank       <= w_blank_d;
            r_pat         <= w_pat_d;
            r_f0          <= w_f0_d;
            r_frame_count <= w_frame_count_d;
            r_frame_done  <= w_frame_done_d;
            r_tdata       <= w_tdata_d;
            r_tvalid      <= w_tvalid_d;
            r_tuser       <= w_tuser_d;
            r_tlast       <= w_tlast_d;
        end
    end

    assign m_axis_video_tdata  = r_tdata;
    assign m_axis_video_tvalid = r_tvalid;
    assign m_axis_video_tuser  = r_tuser;
    assign m_axis_video_tlast  = r_tlast;
    assign frame_done          = r_frame_done;
    assign frame_count         = r_frame_count;

endmodule

// File: tb/tb_axis_video_pattern_gen.sv
// Scoreboard bench for axis_video_pattern_gen on a 16x4 frame with 2/3-cycle blanking.
module tb_axis_video_pattern_gen;

    localparam int H  = 16;
    localparam int V  = 4;
    localparam int HB = 2;
    localparam int VB = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        tready;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tuser;
    logic        tlast;
    logic        frame_done;
    logic [15:0] frame_count;

    always #5 clk = ~clk;

    axis_video_pattern_gen #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .enable              (enable),
        .pattern_sel         (pattern_sel),
        .m_axis_video_tready (tready),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .frame_done          (frame_done),
        .frame_count         (frame_count)
    );

    typedef struct {
        logic [23:0] data;
        logic        user;
        logic        last;
        logic        eof;
    } beat_t;

    beat_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int          beats     = 0;
    int          done_cnt  = 0;
    int          gap       = 0;
    int          gap_exp   = 0;
    bit          cont      = 1'b0;
    bit          rand_rdy  = 1'b0;
    bit          stall_prv = 1'b0;
    logic [23:0] prv_data;
    logic        prv_user;
    logic        prv_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_px(input int pat, input int x, input int y,
                                             input bit f0);
        logic [7:0] x8;
        logic [7:0] y8;
        x8 = 8'(x);
        y8 = 8'(y);
        case (pat)
            0: begin
                case (x / (H / 8))
                    0:       return 24'hFFFFFF;
                    1:       return 24'hFFFF00;
                    2:       return 24'h00FFFF;
                    3:       return 24'h00FF00;
                    4:       return 24'hFF00FF;
                    5:       return 24'hFF0000;
                    6:       return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            1:       return {x8, x8, x8};
            2:       return {y8, y8, y8};
            default: return ((((x >> 3) ^ (y >> 3)) & 1) ^ int'(f0)) != 0 ? 24'hFFFFFF : 24'h0;
        endcase
    endfunction

    task automatic push_frame(input int pat, input bit f0);
        beat_t b;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                b.data = model_px(pat, x, y, f0);
                b.user = (x == 0 && y == 0);
                b.last = (x == H - 1);
                b.eof  = (x == H - 1 && y == V - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // Monitor: sampled on the falling edge, i.e. the values the next rising edge sees.
    always @(negedge clk) begin
        beat_t e;
        if (frame_done === 1'b1) done_cnt++;
        if (tvalid === 1'b1) begin
            if (stall_prv) begin
                check("stall_tdata", 32'(tdata), 32'(prv_data));
                check("stall_tuser", 32'(tuser), 32'(prv_user));
                check("stall_tlast", 32'(tlast), 32'(prv_last));
            end
            if (gap_exp != 0) check("blank_gap", gap, gap_exp);
            gap_exp = 0;
            gap     = 0;
            if (tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", 32'(tdata), 32'(e.data));
                    check("tuser", 32'(tuser), 32'(e.user));
                    check("tlast", 32'(tlast), 32'(e.last));
                    if (e.last) gap_exp = e.eof ? (cont ? VB : 0) : HB;
                end
                beats++;
            end
            stall_prv = !tready;
            prv_data  = tdata;
            prv_user  = tuser;
            prv_last  = tlast;
        end else begin
            gap++;
            stall_prv = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) tready = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_beats(input int n);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (beats >= n) break;
        end
        if (i == 2000) check("wait_beats_timeout", 32'(beats), 32'(n));
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn        = 1'b0;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        tready      = 1'b1;

        // Reset and idle
        repeat (5) @(posedge clk);
        #1;
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tuser", 32'(tuser), 32'd0);
        check("rst_tlast", 32'(tlast), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_fcount", 32'(frame_count), 32'd0);
        rstn = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("idle_tvalid", 32'(tvalid), 32'd0);
        check("idle_fcount", 32'(frame_count), 32'd0);
        check("idle_done_cnt", 32'(done_cnt), 32'd0);

        // H-ramp, full-rate ready; enable released early, frame must still complete
        pattern_sel = 2'd1;
        push_frame(1, 1'b0);
        beats  = 0;
        enable = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        drain();
        check("hramp_beats", 32'(beats), 32'd64);
        check("hramp_done_cnt", 32'(done_cnt), 32'd1);
        check("hramp_fcount", 32'(frame_count), 32'd1);
        check("hramp_tvalid_after", 32'(tvalid), 32'd0);

        // Colour bars with random backpressure; enable dropped at beat 20
        pattern_sel = 2'd0;
        push_frame(0, 1'b1);
        beats    = 0;
        rand_rdy = 1'b1;
        enable   = 1'b1;
        wait_beats(20);
        #1;
        enable = 1'b0;
        drain();
        rand_rdy = 1'b0;
        tready   = 1'b1;
        check("bars_beats", 32'(beats), 32'd64);
        check("bars_done_cnt", 32'(done_cnt), 32'd2);
        check("bars_fcount", 32'(frame_count), 32'd2);
        check("bars_tvalid_after", 32'(tvalid), 32'd0);

        // Two back-to-back frames; pattern_sel changes mid-frame 0, applies at frame 1
        pattern_sel = 2'd0;
        push_frame(0, 1'b0);
        push_frame(2, 1'b1);
        beats  = 0;
        cont   = 1'b1;
        enable = 1'b1;
        wait_beats(10);
        #1;
        pattern_sel = 2'd2;
        wait_beats(64 + 10);
        #1;
        enable = 1'b0;
        cont   = 1'b0;
        drain();
        check("two_beats", 32'(beats), 32'd128);
        check("two_done_cnt", 32'(done_cnt), 32'd4);
        check("two_fcount", 32'(frame_count), 32'd4);

        // Checker frame aborted by a one-edge reset at beat 10, then restarted
        pattern_sel = 2'd3;
        push_frame(3, 1'b0);
        beats  = 0;
        enable = 1'b1;
        wait_beats(10);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check("abort_tvalid", 32'(tvalid), 32'd0);
        check("abort_fcount", 32'(frame_count), 32'd0);
        exp_q.delete();
        gap_exp  = 0;
        push_frame(3, 1'b0);
        beats    = 0;
        done_cnt = 0;
        repeat (5) @(posedge clk);
        #1;
        enable = 1'b0;
        drain();
        check("restart_beats", 32'(beats), 32'd64);
        check("restart_done_cnt", 32'(done_cnt), 32'd1);
        check("restart_fcount", 32'(frame_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1);
    end

endmodule
